bpred_update_queue: RTL and testbench

- Buffers resolved-branch outcomes from execute and drains them in order into the gshare predictor's update port.
- Sits between the execute stage and bpredTop.
- Decouples execute from predictor stalls; each entry carries PC4, target, direction, miss flag and the bimodal/history snapshot taken at fetch.
- One predictor update is issued per unstalled cycle.

---
 rtl/bpred_pkg.sv | 24 ++
 rtl/bpred_update_queue_if.sv | 50 +++++
 rtl/bpred_uq_stats.sv | 58 +++++
 rtl/bpred_update_queue.sv | 113 +++++++++++
 tb/tb_bpred_update_queue.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpred_pkg.sv
// bpred_pkg
// Shared types and constants for the branch-predictor update path.
//   - bpred_update_t : one resolved-branch update at the default widths
//   - PC_W, BIMODAL_W: default field widths
//   - DBG_*          : encodings for the update-queue debug read select
package bpred_pkg;

    localparam int PC_W      = 32;
    localparam int BIMODAL_W = 12;

    typedef struct packed {
        logic [PC_W-1:0]      pc4;
        logic [PC_W-1:0]      target;
        logic                 dir;
        logic                 miss;
        logic [BIMODAL_W-1:0] bimodal;
    } bpred_update_t;

    localparam logic [1:0] DBG_ACCEPT = 2'd0;
    localparam logic [1:0] DBG_MISS   = 2'd1;
    localparam logic [1:0] DBG_DROP   = 2'd2;
    localparam logic [1:0] DBG_COUNT  = 2'd3;

endpackage

// File: rtl/bpred_update_queue_if.sv
// bpred_update_queue_if
// Bundles the execute-side enqueue port, the predictor-side drain port and
// the debug read port of the branch update queue.
//   master : the surrounding pipeline (drives execute_*, soin_* signals)
//   slave  : the update queue (drives uq_* signals)
interface bpred_update_queue_if #(
    parameter int PC_W      = 32,
    parameter int BIMODAL_W = 12
);

    logic                 execute_bpredictor_update;
    logic [PC_W-1:0]      execute_bpredictor_PC4;
    logic [PC_W-1:0]      execute_bpredictor_target;
    logic                 execute_bpredictor_dir;
    logic                 execute_bpredictor_miss;
    logic [BIMODAL_W-1:0] execute_bpredictor_bimodal;
    logic                 uq_execute_full;

    logic                 soin_bpredictor_stall;
    logic                 uq_bpredictor_update;
    logic [PC_W-1:0]      uq_bpredictor_PC4;
    logic [PC_W-1:0]      uq_bpredictor_target;
    logic                 uq_bpredictor_dir;
    logic                 uq_bpredictor_miss;
    logic [BIMODAL_W-1:0] uq_bpredictor_bimodal;

    logic [1:0]           soin_uq_debug_sel;
    logic [31:0]          uq_soin_debug;

    modport master (
        output execute_bpredictor_update, execute_bpredictor_PC4,
               execute_bpredictor_target, execute_bpredictor_dir,
               execute_bpredictor_miss, execute_bpredictor_bimodal,
               soin_bpredictor_stall, soin_uq_debug_sel,
        input  uq_execute_full, uq_bpredictor_update, uq_bpredictor_PC4,
               uq_bpredictor_target, uq_bpredictor_dir, uq_bpredictor_miss,
               uq_bpredictor_bimodal, uq_soin_debug
    );

    modport slave (
        input  execute_bpredictor_update, execute_bpredictor_PC4,
               execute_bpredictor_target, execute_bpredictor_dir,
               execute_bpredictor_miss, execute_bpredictor_bimodal,
               soin_bpredictor_stall, soin_uq_debug_sel,
        output uq_execute_full, uq_bpredictor_update, uq_bpredictor_PC4,
               uq_bpredictor_target, uq_bpredictor_dir, uq_bpredictor_miss,
               uq_bpredictor_bimodal, uq_soin_debug
    );

endinterface

// File: rtl/bpred_uq_stats.sv
// bpred_uq_stats
// Saturating statistics counters for the branch update queue plus the
// debug read mux.
//   clk, reset   : clock, asynchronous active-low reset
//   enq_accept   : an update was written into the queue this cycle
//   enq_miss     : miss flag of that accepted update
//   enq_drop     : an update arrived while the queue was full
//   count        : current queue occupancy
//   sel          : debug select (DBG_ACCEPT / DBG_MISS / DBG_DROP / DBG_COUNT)
//   debug        : selected 32-bit debug value
module bpred_uq_stats
    import bpred_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_accept,
    input  logic             enq_miss,
    input  logic             enq_drop,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       sel,
    output logic [31:0]      debug
);

    logic [31:0] accept_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] drop_cnt;

    // Counters stick at all-ones instead of wrapping so a long run never
    // reports a misleadingly small number.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accept_cnt <= '0;
            miss_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            if (enq_accept && (accept_cnt != '1))
                accept_cnt <= accept_cnt + 32'd1;
            if (enq_accept && enq_miss && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 32'd1;
            if (enq_drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 32'd1;
        end
    end

    always_comb begin
        debug = 32'd0;
        case (sel)
            DBG_ACCEPT: debug = accept_cnt;
            DBG_MISS:   debug = miss_cnt;
            DBG_DROP:   debug = drop_cnt;
            DBG_COUNT:  debug = 32'(count);
            default:    debug = 32'd0;
        endcase
    end

endmodule

// File: rtl/bpred_update_queue.sv
// bpred_update_queue
// In-order FIFO of resolved-branch updates between execute and the gshare
// predictor. Execute enqueues one update per cycle; the predictor drains
// one per cycle unless it stalls. No same-cycle bypass: an entry written
// at one edge is visible at the head output from the next cycle on.
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-low reset; discards everything queued
//   uq     : bpred_update_queue_if.slave (enqueue, drain and debug ports)
// Parameters: DEPTH (power of two, >= 2), PC_W, BIMODAL_W.
// Optional build macro BPRED_UQ_STATS_EN adds the bpred_uq_stats counters;
// without it uq_soin_debug reads as zero.
module bpred_update_queue
    import bpred_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PC_W      = bpred_pkg::PC_W,
    parameter int BIMODAL_W = bpred_pkg::BIMODAL_W
) (
    input  logic                   clk,
    input  logic                   reset,
    bpred_update_queue_if.slave    uq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]      pc4;
        logic [PC_W-1:0]      target;
        logic                 dir;
        logic                 miss;
        logic [BIMODAL_W-1:0] bimodal;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic full;
    logic enq_accept;
    logic enq_drop;
    logic deq;
    entry_t enq_entry;

    // Full depends only on registered occupancy, so a dequeue in the same
    // cycle never frees a slot for an incoming update.
    assign full       = (count == CNT_W'(DEPTH));
    assign enq_accept = uq.execute_bpredictor_update && !full;
    assign enq_drop   = uq.execute_bpredictor_update && full;
    assign deq        = (count != '0) && !uq.soin_bpredictor_stall;

    assign enq_entry = '{
        pc4:     uq.execute_bpredictor_PC4,
        target:  uq.execute_bpredictor_target,
        dir:     uq.execute_bpredictor_dir,
        miss:    uq.execute_bpredictor_miss,
        bimodal: uq.execute_bpredictor_bimodal
    };

    // Pointers wrap naturally at DEPTH because it is a power of two.
    // Occupancy only changes when exactly one of enqueue/dequeue happens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (enq_accept) begin
                mem[tail] <= enq_entry;
                tail      <= tail + PTR_W'(1);
            end
            if (deq)
                head <= head + PTR_W'(1);
            if (enq_accept && !deq)
                count <= count + CNT_W'(1);
            else if (!enq_accept && deq)
                count <= count - CNT_W'(1);
        end
    end

    // Head fields come straight from storage; when empty they show whatever
    // the head slot holds (zero after reset), never X.
    assign uq.uq_execute_full       = full;
    assign uq.uq_bpredictor_update  = deq;
    assign uq.uq_bpredictor_PC4     = mem[head].pc4;
    assign uq.uq_bpredictor_target  = mem[head].target;
    assign uq.uq_bpredictor_dir     = mem[head].dir;
    assign uq.uq_bpredictor_miss    = mem[head].miss;
    assign uq.uq_bpredictor_bimodal = mem[head].bimodal;

`ifdef BPRED_UQ_STATS_EN
    bpred_uq_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk        (clk),
        .reset      (reset),
        .enq_accept (enq_accept),
        .enq_miss   (uq.execute_bpredictor_miss),
        .enq_drop   (enq_drop),
        .count      (count),
        .sel        (uq.soin_uq_debug_sel),
        .debug      (uq.uq_soin_debug)
    );
`else
    logic unused_stats;
    assign unused_stats     = ^{uq.soin_uq_debug_sel, enq_drop};
    assign uq.uq_soin_debug = 32'd0;
`endif

endmodule

// File: tb/tb_bpred_update_queue.sv
// tb_bpred_update_queue
// Self-checking bench for bpred_update_queue (DEPTH=4, PC_W=32, BIMODAL_W=12).
// A queue of expected entries is pushed on every accepted enqueue and popped
// when the DUT presents an update. Table rows carry explicit expected
// update/full/PC4 values. Build with +define+BPRED_UQ_STATS_EN to also check
// the statistics counters.
module tb_bpred_update_queue;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] target;
        logic        dir;
        logic        miss;
        logic [11:0] bimodal;
    } ent_t;

    typedef struct {
        logic        enq;
        logic [31:0] pc4;
        logic        miss;
        logic        stall;
        logic        expUpd;
        logic        expFull;
        logic [31:0] expPc4;
    } vec_t;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    bpred_update_queue_if #(.PC_W(32), .BIMODAL_W(12)) bus ();

    bpred_update_queue #(
        .DEPTH     (DEPTH),
        .PC_W      (32),
        .BIMODAL_W (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .uq    (bus)
    );

    int   testsRun;
    int   testsFailed;
    ent_t sb [$];
    int   accepts;
    int   misses;
    int   drops;
    logic sampledUpd;
    logic sampledFull;
    logic [31:0] sampledPc4;
    vec_t vecs [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mkEntry(input logic [31:0] pc4, input logic miss);
        ent_t e;
        e.pc4     = pc4;
        e.target  = (pc4 << 4) ^ 32'h0000_A000;
        e.dir     = ~pc4[2];
        e.miss    = miss;
        e.bimodal = pc4[11:0] ^ 12'h5A5;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the scoreboard, then
    // advance the model as the DUT will at the next rising edge.
    task automatic applyStimulus(input logic enq, input ent_t e, input logic stall);
        logic expUpd;
        logic fullPre;
        @(negedge clk);
        bus.execute_bpredictor_update  = enq;
        bus.execute_bpredictor_PC4     = e.pc4;
        bus.execute_bpredictor_target  = e.target;
        bus.execute_bpredictor_dir     = e.dir;
        bus.execute_bpredictor_miss    = e.miss;
        bus.execute_bpredictor_bimodal = e.bimodal;
        bus.soin_bpredictor_stall      = stall;
        #1;
        fullPre = (sb.size() == DEPTH);
        expUpd  = (sb.size() != 0) && !stall;
        sampledUpd  = bus.uq_bpredictor_update;
        sampledFull = bus.uq_execute_full;
        sampledPc4  = bus.uq_bpredictor_PC4;
        checkOutput("full", 64'(bus.uq_execute_full), 64'(fullPre));
        checkOutput("update", 64'(bus.uq_bpredictor_update), 64'(expUpd));
        if (sb.size() != 0) begin
            checkOutput("head_pc4", 64'(bus.uq_bpredictor_PC4), 64'(sb[0].pc4));
            checkOutput("head_target", 64'(bus.uq_bpredictor_target), 64'(sb[0].target));
            checkOutput("head_dir", 64'(bus.uq_bpredictor_dir), 64'(sb[0].dir));
            checkOutput("head_miss", 64'(bus.uq_bpredictor_miss), 64'(sb[0].miss));
            checkOutput("head_bimodal", 64'(bus.uq_bpredictor_bimodal), 64'(sb[0].bimodal));
        end
        if (expUpd)
            void'(sb.pop_front());
        if (enq) begin
            if (fullPre) begin
                drops++;
            end else begin
                sb.push_back(e);
                accepts++;
                if (e.miss)
                    misses++;
            end
        end
    endtask

    task automatic idle(input logic stall);
        applyStimulus(1'b0, mkEntry(32'd0, 1'b0), stall);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        accepts = 0;
        misses  = 0;
        drops   = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        ent_t e;
        testsRun    = 0;
        testsFailed = 0;
        accepts = 0;
        misses  = 0;
        drops   = 0;
        reset = 1'b0;
        bus.execute_bpredictor_update  = 1'b0;
        bus.execute_bpredictor_PC4     = '0;
        bus.execute_bpredictor_target  = '0;
        bus.execute_bpredictor_dir     = 1'b0;
        bus.execute_bpredictor_miss    = 1'b0;
        bus.execute_bpredictor_bimodal = '0;
        bus.soin_bpredictor_stall      = 1'b0;
        bus.soin_uq_debug_sel          = 2'd0;

        // Reset state
        #12;
        checkOutput("rst_update", 64'(bus.uq_bpredictor_update), 64'd0);
        checkOutput("rst_full", 64'(bus.uq_execute_full), 64'd0);
        checkOutput("rst_pc4", 64'(bus.uq_bpredictor_PC4), 64'd0);
        checkOutput("rst_bimodal", 64'(bus.uq_bpredictor_bimodal), 64'd0);
        checkOutput("rst_debug", 64'(bus.uq_soin_debug), 64'd0);
        doReset();

        // Single entry: visible exactly one cycle after enqueue
        e = '{pc4: 32'd128, target: 32'd0, dir: 1'b1, miss: 1'b0, bimodal: 12'h003};
        applyStimulus(1'b1, e, 1'b0);
        checkOutput("t1_same_cycle", 64'(sampledUpd), 64'd0);
        idle(1'b0);
        checkOutput("t1_update", 64'(sampledUpd), 64'd1);
        checkOutput("t1_pc4", 64'(sampledPc4), 64'd128);
        checkOutput("t1_bimodal", 64'(bus.uq_bpredictor_bimodal), 64'd3);
        idle(1'b0);
        checkOutput("t1_after", 64'(sampledUpd), 64'd0);

        // Fill under stall, drop the 5th, drain in order
        vecs.push_back('{1'b1, 32'd4,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b1, 32'd8,  1'b1, 1'b1, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b1, 32'd12, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b1, 32'd16, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b1, 32'd20, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0});
        vecs.push_back('{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b1, 32'd4});
        vecs.push_back('{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd8});
        vecs.push_back('{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd12});
        vecs.push_back('{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd16});
        vecs.push_back('{1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].enq, mkEntry(vecs[i].pc4, vecs[i].miss), vecs[i].stall);
            checkOutput($sformatf("vec%0d_update", i), 64'(sampledUpd), 64'(vecs[i].expUpd));
            checkOutput($sformatf("vec%0d_full", i), 64'(sampledFull), 64'(vecs[i].expFull));
            if (vecs[i].expUpd)
                checkOutput($sformatf("vec%0d_pc4", i), 64'(sampledPc4), 64'(vecs[i].expPc4));
        end

        // Steady enqueue/dequeue: occupancy stays at one through two wraps
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, mkEntry(32'd32 + 32'(4 * i), 1'(i % 3 == 0)), 1'b0);
            if (i > 0) begin
                checkOutput("steady_update", 64'(sampledUpd), 64'd1);
                checkOutput("steady_pc4", 64'(sampledPc4), 64'(32 + 4 * (i - 1)));
            end
        end
        idle(1'b0);
        checkOutput("steady_last_pc4", 64'(sampledPc4), 64'd68);
        idle(1'b0);
        checkOutput("steady_empty", 64'(sampledUpd), 64'd0);

        // Stall toggling with three queued entries
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, mkEntry(32'h200 + 32'(4 * i), 1'b0), 1'b1);
        idle(1'b1);
        checkOutput("tog_stall0_pc4", 64'(sampledPc4), 64'h200);
        idle(1'b0);
        checkOutput("tog_go0_pc4", 64'(sampledPc4), 64'h200);
        idle(1'b1);
        checkOutput("tog_stall1_pc4", 64'(sampledPc4), 64'h204);
        checkOutput("tog_stall1_upd", 64'(sampledUpd), 64'd0);
        idle(1'b0);
        checkOutput("tog_go1_pc4", 64'(sampledPc4), 64'h204);
        idle(1'b0);
        idle(1'b0);
        checkOutput("tog_empty", 64'(sampledUpd), 64'd0);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, mkEntry(32'h300 + 32'(4 * i), 1'b1), 1'b1);
        idle(1'b0);
        @(posedge clk);
        #2;
        checkOutput("mid_drain_update", 64'(bus.uq_bpredictor_update), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("async_update", 64'(bus.uq_bpredictor_update), 64'd0);
        checkOutput("async_full", 64'(bus.uq_execute_full), 64'd0);
        checkOutput("async_pc4", 64'(bus.uq_bpredictor_PC4), 64'd0);
        sb.delete();
        accepts = 0;
        misses  = 0;
        drops   = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            checkOutput("post_reset_quiet", 64'(sampledUpd), 64'd0);
        end

        // Statistics: 5 accepted (2 misses) and 1 dropped
        doReset();
        applyStimulus(1'b1, mkEntry(32'h400, 1'b1), 1'b1);
        applyStimulus(1'b1, mkEntry(32'h404, 1'b1), 1'b1);
        applyStimulus(1'b1, mkEntry(32'h408, 1'b0), 1'b1);
        applyStimulus(1'b1, mkEntry(32'h40C, 1'b0), 1'b1);
        applyStimulus(1'b1, mkEntry(32'h410, 1'b1), 1'b1);
        idle(1'b0);
        applyStimulus(1'b1, mkEntry(32'h414, 1'b0), 1'b1);
        @(negedge clk);
        bus.execute_bpredictor_update = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.soin_uq_debug_sel = 2'(s);
            #1;
`ifdef BPRED_UQ_STATS_EN
            case (s)
                0: checkOutput("dbg_accept", 64'(bus.uq_soin_debug), 64'd5);
                1: checkOutput("dbg_miss", 64'(bus.uq_soin_debug), 64'd2);
                2: checkOutput("dbg_drop", 64'(bus.uq_soin_debug), 64'd1);
                default: checkOutput("dbg_count", 64'(bus.uq_soin_debug), 64'(sb.size()));
            endcase
`else
            checkOutput("dbg_disabled", 64'(bus.uq_soin_debug), 64'd0);
`endif
        end
        for (int i = 0; i < 5; i++)
            idle(1'b0);
        checkOutput("final_empty", 64'(sampledUpd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
